// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared constants and action encodings for the Booth multiplier slice
package booth_pkg;

  localparam int BOOTH_WIDTH = 16;

  // addsub strobe encoding, shared with the Booth controller
  localparam logic BOOTH_ADD = 1'b1;
  localparam logic BOOTH_SUB = 1'b0;

  typedef enum logic [1:0] {
    A_HOLD  = 2'd0,
    A_CLR   = 2'd1,
    A_LOAD  = 2'd2,
    A_SHIFT = 2'd3
  } a_op_e;

  typedef enum logic [1:0] {
    Q_HOLD  = 2'd0,
    Q_CLR   = 2'd1,
    Q_LOAD  = 2'd2,
    Q_SHIFT = 2'd3
  } q_op_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_datapath_if.sv
// rtl/booth_datapath_if.sv - strobe/status bundle between the Booth controller and datapath
interface booth_datapath_if
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
);

  logic [WIDTH-1:0]   data_in;
  logic               ldA;
  logic               clrA;
  logic               sftA;
  logic               ldQ;
  logic               clrQ;
  logic               sftQ;
  logic               ldM;
  logic               clrff;
  logic               ldff;
  logic               addsub;
  logic               ldcnt;
  logic               decr;
  logic               q0;
  logic               qm1;
  logic               eqz;
  logic [2*WIDTH-1:0] product;

  modport master (
    output data_in, ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM,
    output clrff, ldff, addsub, ldcnt, decr,
    input  q0, qm1, eqz, product
  );

  modport slave (
    input  data_in, ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM,
    input  clrff, ldff, addsub, ldcnt, decr,
    output q0, qm1, eqz, product
  );

endinterface

// File: rtl/booth_counter.sv
// rtl/booth_counter.sv - iteration down-counter: load to WIDTH, saturating decrement, zero flag
module booth_counter
  import booth_pkg::*;
#(
  parameter  int WIDTH = BOOTH_WIDTH,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic ldcnt,
  input  logic decr,
  output logic eqz
);

  logic [CNT_W-1:0] count;

  // decrement stops at zero so an extra decr pulse cannot wrap to a large count
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (ldcnt) begin
      count <= CNT_W'(WIDTH);
    end else if (decr && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign eqz = (count == '0);

endmodule

// File: rtl/booth_datapath.sv
// rtl/booth_datapath.sv - radix-2 Booth datapath: A, Q, M, Q[-1] and the iteration counter
module booth_datapath
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  booth_datapath_if.slave  bus
);

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic             qm1_r;
  logic [WIDTH-1:0] addsub_res;
  a_op_e            a_op;
  q_op_e            q_op;

  // resolve competing strobes into a single action per register
  always_comb begin
    a_op = A_HOLD;
    if (bus.clrA) begin
      a_op = A_CLR;
    end else if (bus.ldA) begin
      a_op = A_LOAD;
    end else if (bus.sftA) begin
      a_op = A_SHIFT;
    end
  end

  always_comb begin
    q_op = Q_HOLD;
    if (bus.clrQ) begin
      q_op = Q_CLR;
    end else if (bus.ldQ) begin
      q_op = Q_LOAD;
    end else if (bus.sftQ) begin
      q_op = Q_SHIFT;
    end
  end

  assign addsub_res = (bus.addsub == BOOTH_ADD) ? (a_r + m_r) : (a_r - m_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
    end else begin
      case (a_op)
        A_CLR:   a_r <= '0;
        A_LOAD:  a_r <= addsub_res;
        A_SHIFT: a_r <= {a_r[WIDTH-1], a_r[WIDTH-1:1]};
        default: a_r <= a_r;
      endcase
    end
  end

  // Q shifts in the pre-edge A[0], so A and Q move together as one {A,Q} word
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else begin
      case (q_op)
        Q_CLR:   q_r <= '0;
        Q_LOAD:  q_r <= bus.data_in;
        Q_SHIFT: q_r <= {a_r[0], q_r[WIDTH-1:1]};
        default: q_r <= q_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_r   <= '0;
      qm1_r <= 1'b0;
    end else begin
      if (bus.ldM) begin
        m_r <= bus.data_in;
      end
      if (bus.clrff) begin
        qm1_r <= 1'b0;
      end else if (bus.ldff) begin
        qm1_r <= q_r[0];
      end
    end
  end

  booth_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .ldcnt (bus.ldcnt),
    .decr  (bus.decr),
    .eqz   (bus.eqz)
  );

  assign bus.q0      = q_r[0];
  assign bus.qm1     = qm1_r;
  assign bus.product = {a_r, q_r};

endmodule

// File: tb/tb_booth_datapath.sv
// tb/tb_booth_datapath.sv - directed bench for booth_datapath with an arithmetic reference model
module tb_booth_datapath;

  localparam logic [12:0] RST   = 13'h0001;
  localparam logic [12:0] LDA   = 13'h0002;
  localparam logic [12:0] CLRA  = 13'h0004;
  localparam logic [12:0] SFTA  = 13'h0008;
  localparam logic [12:0] LDQ   = 13'h0010;
  localparam logic [12:0] CLRQ  = 13'h0020;
  localparam logic [12:0] SFTQ  = 13'h0040;
  localparam logic [12:0] LDM   = 13'h0080;
  localparam logic [12:0] CLRFF = 13'h0100;
  localparam logic [12:0] LDFF  = 13'h0200;
  localparam logic [12:0] ADD   = 13'h0400;
  localparam logic [12:0] LDCNT = 13'h0800;
  localparam logic [12:0] DECR  = 13'h1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  logic [15:0] m_a, m_q, m_m;
  logic        m_qm1;
  int          m_cnt;

  booth_datapath_if #(.WIDTH(16)) bus ();

  booth_datapath #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: registers described as arithmetic on the values they hold
  task automatic model_step(input logic [12:0] s, input logic [15:0] d);
    logic [15:0] na, nq, nm;
    logic        nqm1;
    int          nc;
    if ((s & RST) != 0) begin
      m_a = 0; m_q = 0; m_m = 0; m_qm1 = 0; m_cnt = 0;
      return;
    end
    na = m_a; nq = m_q; nm = m_m; nqm1 = m_qm1; nc = m_cnt;
    if ((s & CLRA) != 0)      na = 16'h0;
    else if ((s & LDA) != 0)  na = ((s & ADD) != 0) ? 16'(int'(m_a) + int'(m_m)) : 16'(int'(m_a) - int'(m_m));
    else if ((s & SFTA) != 0) na = 16'($signed(m_a) >>> 1);
    if ((s & CLRQ) != 0)      nq = 16'h0;
    else if ((s & LDQ) != 0)  nq = d;
    else if ((s & SFTQ) != 0) nq = (m_q >> 1) | (m_a[0] ? 16'h8000 : 16'h0000);
    if ((s & LDM) != 0)       nm = d;
    if ((s & CLRFF) != 0)     nqm1 = 1'b0;
    else if ((s & LDFF) != 0) nqm1 = m_q[0];
    if ((s & LDCNT) != 0)     nc = 16;
    else if ((s & DECR) != 0) nc = (m_cnt > 0) ? m_cnt - 1 : 0;
    m_a = na; m_q = nq; m_m = nm; m_qm1 = nqm1; m_cnt = nc;
  endtask

  task automatic go(input logic [12:0] s, input logic [15:0] d);
    @(negedge clk);
    rst         = s[0];
    bus.ldA     = s[1];
    bus.clrA    = s[2];
    bus.sftA    = s[3];
    bus.ldQ     = s[4];
    bus.clrQ    = s[5];
    bus.sftQ    = s[6];
    bus.ldM     = s[7];
    bus.clrff   = s[8];
    bus.ldff    = s[9];
    bus.addsub  = s[10];
    bus.ldcnt   = s[11];
    bus.decr    = s[12];
    bus.data_in = d;
    @(posedge clk);
    model_step(s, d);
    #1;
  endtask

  // controller stand-in: decisions come from the reference model's q0/qm1
  task automatic booth_run(input logic [15:0] m, input logic [15:0] q, input int iters);
    go(LDM, m);
    go(LDQ | CLRA | CLRFF | LDCNT, q);
    for (int i = 0; i < iters; i++) begin
      if (m_q[0] && !m_qm1)      go(LDA, 16'h0);
      else if (!m_q[0] && m_qm1) go(LDA | ADD, 16'h0);
      go(SFTA | SFTQ | LDFF | DECR, 16'h0);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_product", bus.product, {m_a, m_q});
      chk("cyc_q0", 32'(bus.q0), 32'(m_q[0]));
      chk("cyc_qm1", 32'(bus.qm1), 32'(m_qm1));
      chk("cyc_eqz", 32'(bus.eqz), 32'(m_cnt == 0));
    end
  end

  initial begin
    logic [31:0] exp_p;
    bus.data_in = '0;
    {bus.ldA, bus.clrA, bus.sftA, bus.ldQ, bus.clrQ, bus.sftQ, bus.ldM} = '0;
    {bus.clrff, bus.ldff, bus.addsub, bus.ldcnt, bus.decr} = '0;
    go(RST, 16'h0);
    chk("rst0_product", bus.product, 32'h0);
    chk("rst0_eqz", 32'(bus.eqz), 32'd1);
    chk_en = 1'b1;

    // reset clears arbitrary state and beats every strobe
    go(LDM, 16'h1234);
    go(LDA | ADD, 16'h0);
    go(LDQ, 16'hABCD);
    go(LDFF | LDCNT, 16'h0);
    chk("pre_rst_product", bus.product, 32'h1234ABCD);
    go(13'h1FFF, 16'hFFFF);
    chk("rst_product", bus.product, 32'h0);
    chk("rst_q0", 32'(bus.q0), 32'd0);
    chk("rst_qm1", 32'(bus.qm1), 32'd0);
    chk("rst_eqz", 32'(bus.eqz), 32'd1);
    go(13'h0, 16'h5555);

    // counter: 16 decrements to zero, saturation, load beats decr
    go(LDCNT, 16'h0);
    for (int i = 1; i <= 16; i++) begin
      go(DECR, 16'h0);
      chk($sformatf("cnt_eqz_%0d", i), 32'(bus.eqz), (i == 16) ? 32'd1 : 32'd0);
    end
    go(DECR, 16'h0);
    chk("cnt_sat_eqz", 32'(bus.eqz), 32'd1);
    go(LDCNT | DECR, 16'h0);
    chk("cnt_ld_decr", 32'(bus.eqz), 32'd0);
    for (int i = 1; i <= 16; i++) go(DECR, 16'h0);
    chk("cnt_ld_decr_16", 32'(bus.eqz), 32'd1);

    // combined shift: A=0x8001 Q=0x0003 qm1=0
    go(LDM | CLRA, 16'h8001);
    go(LDA | ADD | CLRFF, 16'h0);
    go(LDQ, 16'h0003);
    chk("shift_pre", bus.product, 32'h80010003);
    go(SFTA | SFTQ | LDFF, 16'h0);
    chk("shift_product", bus.product, 32'hC0008001);
    chk("shift_qm1", 32'(bus.qm1), 32'd1);
    go(13'h0, 16'hFFFF);
    chk("hold_product", bus.product, 32'hC0008001);

    // A precedence
    go(CLRA | LDA | ADD, 16'h0);
    chk("clrA_over_ldA", {16'h0, bus.product[31:16]}, 32'h0);
    go(LDM, 16'h0002);
    go(LDA | ADD, 16'h0);
    go(LDM, 16'h0001);
    go(LDA | SFTA | ADD, 16'h0);
    chk("ldA_over_sftA", {16'h0, bus.product[31:16]}, 32'h0003);

    // full multiplies
    booth_run(16'h0007, 16'h0003, 16);
    chk("mul_7x3", bus.product, 32'h00000015);
    chk("mul_7x3_eqz", 32'(bus.eqz), 32'd1);
    booth_run(16'hFFFB, 16'h0003, 16);
    chk("mul_m5x3", bus.product, 32'hFFFFFFF1);
    exp_p = 32'(int'($signed(16'h0123)) * int'($signed(16'hFF9C)));
    booth_run(16'h0123, 16'hFF9C, 16);
    chk("mul_0123xff9c", bus.product, exp_p);

    // reset mid-multiply, then a fresh run
    booth_run(16'h0007, 16'h0003, 5);
    go(RST, 16'h0);
    chk("mid_rst_product", bus.product, 32'h0);
    chk("mid_rst_qm1", 32'(bus.qm1), 32'd0);
    chk("mid_rst_eqz", 32'(bus.eqz), 32'd1);
    booth_run(16'h0002, 16'hFFFF, 16);
    chk("mul_2xm1", bus.product, 32'hFFFFFFFE);

    go(13'h0, 16'h0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_datapath.md
Name: booth_datapath

Overview:
Radix-2 Booth multiplier datapath. It holds the accumulator A, multiplier Q, multiplicand M, the Q[-1] flip-flop and the iteration counter. It consumes the per-cycle control strobes from the Booth controller and returns the status bits that controller branches on: q0, qm1 and eqz. Operands arrive over a single shared data bus, M first, then Q. The product is read from {A,Q} once the controller asserts done.

Parameters:
WIDTH, 16, operand width in bits; A, Q and M are each WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
data_in  in  WIDTH  shared operand bus for M and Q
ldA  in  1  A <= A +/- M
clrA  in  1  A <= 0
sftA  in  1  arithmetic right shift of A
ldQ  in  1  Q <= data_in
clrQ  in  1  Q <= 0
sftQ  in  1  right shift of Q, with A[0] entering Q[WIDTH-1]
ldM  in  1  M <= data_in
clrff  in  1  qm1 <= 0
ldff  in  1  qm1 <= Q[0] (pre-shift value)
addsub  in  1  1 = add (A+M), 0 = subtract (A-M)
ldcnt  in  1  count <= WIDTH
decr  in  1  count <= count-1
q0  out  1  Q[0]
qm1  out  1  Q[-1] flip-flop
eqz  out  1  count == 0
product  out  2*WIDTH  {A,Q}

Behaviour:
- Reset: rst=1 at a rising edge forces A=0, Q=0, M=0, qm1=0, count=0. Resulting outputs: q0=0, qm1=0, eqz=1, product=0. rst overrides every strobe in that cycle.
- Timing: all registers update on the rising clk edge, one cycle after the strobe is sampled. q0, qm1, eqz and product are combinational from registers, so they are valid in the cycle after the update and carry no further latency.
- A precedence, per cycle: clrA > ldA > sftA. Only the winning action applies.
- A arithmetic: A <= (A + M) or (A - M), modulo 2^WIDTH, with no overflow flag. The product is exact for all operand pairs except M = -2^(WIDTH-1); that case is out of range and is not checked.
- sftA: A <= {A[WIDTH-1], A[WIDTH-1:1]} (sign-preserving).
- Q precedence: clrQ > ldQ > sftQ.
- sftQ: Q <= {A[0], Q[WIDTH-1:1]}. A[0] is always the pre-edge value, whether or not A also shifts or loads that cycle.
- qm1 precedence: clrff > ldff. ldff captures the pre-edge Q[0], so ldff together with sftQ moves the bit shifted out of Q into qm1.
- M: loads only when ldM=1; otherwise it holds.
- ldQ and ldM asserted in the same cycle: both load the same data_in. This is legal.
- Counter precedence: ldcnt > decr. decr at count=0 holds count at 0 (saturates, no wrap). eqz goes high in the cycle after the WIDTH-th decr following ldcnt.
- No strobes asserted: every register holds.
- Strobe pattern per Booth iteration, as driven by the controller:
  - an optional ldA cycle (addsub chosen from {q0,qm1}: 01 -> add, 10 -> subtract);
  - then one cycle of sftA + sftQ + ldff + decr.
- Reset asserted mid-multiply returns the block to its reset state immediately. No partial product is retained.

Decomposition:
- Shared package booth_pkg holds:
  - the default WIDTH;
  - the addsub encoding constants BOOTH_ADD=1'b1 and BOOTH_SUB=1'b0, used by both the controller and this datapath.
- One sub-module, booth_counter: the CNT_W down-counter with load-to-WIDTH, saturating decrement and the eqz output.
- A, Q, M, qm1 and the adder/subtractor stay inline.

Test Plan:
- Reset: load arbitrary A/Q/M/count values, then assert rst for one cycle -> product=0, q0=0, qm1=0, eqz=1 on the next cycle.
- Counter: ldcnt, then 16 single decr pulses -> eqz=0 after pulses 1..15 and eqz=1 after pulse 16. A 17th decr keeps count=0 and eqz=1. ldcnt together with decr loads 16.
- Shift: preload A=0x8001, Q=0x0003, qm1=0. Apply sftA+sftQ+ldff -> A=0xC000, Q=0x8001, qm1=1.
- Precedence: clrA+ldA in the same cycle -> A=0. ldA+sftA with A=0x0002, M=0x0001, addsub=1 -> A=0x0003, unshifted.
- Full multiply, positive: drive the Booth strobe sequence for 16 iterations with M=0x0007, Q=0x0003 -> product=0x00000015. Repeat with M=0xFFFB (-5), Q=0x0003 -> product=0xFFFFFFF1 (-15).
- Mid-operation reset: rst after iteration 5 of the 0x0007*0x0003 run -> all state zero next cycle. A subsequent fresh 0x0002*0xFFFF run -> product=0xFFFFFFFE.
